// File: rtl/sumador_pkg.sv
// Shared constants for the parametrised counting adder: operation mode
// encodings and an all-ones helper usable for any supported width.
package sumador_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_ADD  = 2'b01;
    localparam logic [1:0] MODE_SUB  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Widest accumulator the all-ones helper can describe.
    localparam int MAX_WIDTH = 64;

    function automatic logic [MAX_WIDTH-1:0] all_ones(input int unsigned w);
        return {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - w);
    endfunction

endpackage

// File: rtl/sumador_addsub_core.sv
// Combinational WIDTH-bit adder/subtractor with a single carry/borrow output.
// For subtraction, cb is set exactly when b > a (unsigned).
module sumador_addsub_core #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] result,
    output logic             cb
);

    logic [WIDTH:0] ext;

    // The extra top bit holds the carry on add and the borrow on subtract.
    assign ext    = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    assign result = ext[WIDTH-1:0];
    assign cb     = ext[WIDTH];

endmodule

// File: rtl/sumador_acc_param.sv
// Registered accumulator with hold/add/subtract/load modes, optional
// saturation, a one-cycle carry/borrow pulse, sticky overflow and wrap counter.
module sumador_acc_param
    import sumador_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int WRAP_W      = 4,
    parameter bit SAT_DEFAULT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [WIDTH-1:0]  step,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              sat_wr,
    input  logic              sat_in,
    input  logic              clear,
    output logic [WIDTH-1:0]  c,
    output logic              cout,
    output logic              ovf,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              sat_mode
);

    localparam logic [MAX_WIDTH-1:0] ONES_EXT = all_ones(WIDTH);
    localparam logic [WIDTH-1:0]     ALL_ONES = ONES_EXT[WIDTH-1:0];
    localparam logic [WRAP_W-1:0]    WRAP_MAX = '1;

    logic [WIDTH-1:0]  core_result;
    logic              core_cb;
    logic              sub_op;

    logic [WIDTH-1:0]  c_next;
    logic              cout_next;
    logic              ovf_next;
    logic [WRAP_W-1:0] wrap_next;

    assign sub_op = (mode == MODE_SUB);

    sumador_addsub_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (c),
        .b      (step),
        .sub    (sub_op),
        .result (core_result),
        .cb     (core_cb)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        c_next    = c;
        cout_next = 1'b0;
        ovf_next  = ovf;
        wrap_next = wrap_cnt;

        if (clear) begin
            c_next    = '0;
            ovf_next  = 1'b0;
            wrap_next = '0;
        end else if (enable) begin
            case (mode)
                MODE_ADD, MODE_SUB: begin
                    cout_next = core_cb;
                    c_next    = core_result;
                    if (core_cb) begin
                        ovf_next = 1'b1;
                        if (wrap_cnt != WRAP_MAX) begin
                            wrap_next = wrap_cnt + WRAP_W'(1);
                        end
                        // Saturation clamps toward the bound that was crossed.
                        if (sat_mode) begin
                            c_next = sub_op ? '0 : ALL_ONES;
                        end
                    end
                end
                MODE_LOAD: c_next = load_val;
                default:   c_next = c;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c        <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
            wrap_cnt <= '0;
        end else begin
            c        <= c_next;
            cout     <= cout_next;
            ovf      <= ovf_next;
            wrap_cnt <= wrap_next;
        end
    end

    // The mode register ignores clear and enable; the op on the write edge
    // still sees the old value because the datapath reads the registered copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_mode <= SAT_DEFAULT;
        end else if (sat_wr) begin
            sat_mode <= sat_in;
        end
    end

endmodule

// File: tb/tb_sumador_acc_param.sv
// Directed self-checking bench for sumador_acc_param (WIDTH=8, WRAP_W=4,
// SAT_DEFAULT=0); each task drives one scenario and checks inline.
module tb_sumador_acc_param;
    import sumador_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [1:0] mode;
    logic [7:0] step;
    logic [7:0] load_val;
    logic       sat_wr;
    logic       sat_in;
    logic       clear;
    logic [7:0] c;
    logic       cout;
    logic       ovf;
    logic [3:0] wrap_cnt;
    logic       sat_mode;

    int checks   = 0;
    int failures = 0;

    sumador_acc_param #(
        .WIDTH       (8),
        .WRAP_W      (4),
        .SAT_DEFAULT (1'b0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .mode     (mode),
        .step     (step),
        .load_val (load_val),
        .sat_wr   (sat_wr),
        .sat_in   (sat_in),
        .clear    (clear),
        .c        (c),
        .cout     (cout),
        .ovf      (ovf),
        .wrap_cnt (wrap_cnt),
        .sat_mode (sat_mode)
    );

    always #5 clk = ~clk;

    // Apply one operation for one edge; outputs are stable 1 ns after the edge.
    // clear and sat_wr are one-shot strobes released after the edge.
    task automatic op(input logic en, input logic [1:0] m,
                      input logic [7:0] s, input logic [7:0] lv);
        enable   = en;
        mode     = m;
        step     = s;
        load_val = lv;
        @(posedge clk);
        #1;
        clear  = 1'b0;
        sat_wr = 1'b0;
        enable = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; mode = MODE_HOLD; step = '0; load_val = '0;
        sat_wr = 1'b0; sat_in = 1'b0; clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (c !== 8'h00) begin failures++; $display("FAIL reset_c: got %h expected %h", c, 8'h00); end
        checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout: got %b expected 0", cout); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        checks++; if (wrap_cnt !== 4'h0) begin failures++; $display("FAIL reset_wrap: got %h expected 0", wrap_cnt); end
        checks++; if (sat_mode !== 1'b0) begin failures++; $display("FAIL reset_sat: got %b expected 0", sat_mode); end
        rst = 1'b0;
        // Build up flag state, then set c=0x5A and sat_mode=1.
        op(1'b1, MODE_LOAD, 8'h00, 8'hFF);
        op(1'b1, MODE_ADD, 8'h01, 8'h00);
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL pre_reset_ovf: got %b expected 1", ovf); end
        sat_wr = 1'b1; sat_in = 1'b1;
        op(1'b1, MODE_LOAD, 8'h00, 8'h5A);
        checks++; if (c !== 8'h5A) begin failures++; $display("FAIL pre_reset_c: got %h expected %h", c, 8'h5A); end
        // Assert reset mid-cycle; effects must be visible before the next edge.
        #2;
        rst = 1'b1;
        #1;
        checks++; if (c !== 8'h00) begin failures++; $display("FAIL async_reset_c: got %h expected 00", c); end
        checks++; if (ovf !== 1'b0 || wrap_cnt !== 4'h0 || cout !== 1'b0) begin
            failures++; $display("FAIL async_reset_flags: got ovf=%b wrap=%h cout=%b expected 0 0 0", ovf, wrap_cnt, cout);
        end
        checks++; if (sat_mode !== 1'b0) begin failures++; $display("FAIL async_reset_sat: got %b expected 0", sat_mode); end
        // An op requested while reset is held has no effect.
        op(1'b1, MODE_LOAD, 8'h00, 8'h77);
        checks++; if (c !== 8'h00) begin failures++; $display("FAIL reset_held_c: got %h expected 00", c); end
        rst = 1'b0;
    endtask

    task automatic test_wrap_add();
        op(1'b1, MODE_LOAD, 8'h00, 8'hF0);
        checks++; if (c !== 8'hF0 || cout !== 1'b0) begin failures++; $display("FAIL wrap_load: got c=%h cout=%b expected f0 0", c, cout); end
        op(1'b1, MODE_ADD, 8'h20, 8'h00);
        checks++; if (c !== 8'h10) begin failures++; $display("FAIL wrap_add_c: got %h expected 10", c); end
        checks++; if (cout !== 1'b1 || ovf !== 1'b1 || wrap_cnt !== 4'h1) begin
            failures++; $display("FAIL wrap_add_flags: got cout=%b ovf=%b wrap=%h expected 1 1 1", cout, ovf, wrap_cnt);
        end
        op(1'b1, MODE_ADD, 8'h01, 8'h00);
        checks++; if (c !== 8'h11 || cout !== 1'b0) begin failures++; $display("FAIL wrap_add2: got c=%h cout=%b expected 11 0", c, cout); end
        checks++; if (ovf !== 1'b1 || wrap_cnt !== 4'h1) begin failures++; $display("FAIL wrap_sticky: got ovf=%b wrap=%h expected 1 1", ovf, wrap_cnt); end
    endtask

    task automatic test_sat_sub();
        clear = 1'b1; sat_wr = 1'b1; sat_in = 1'b1;
        op(1'b0, MODE_HOLD, 8'h00, 8'h00);
        checks++; if (sat_mode !== 1'b1 || ovf !== 1'b0 || wrap_cnt !== 4'h0 || c !== 8'h00) begin
            failures++; $display("FAIL sat_setup: got sat=%b ovf=%b wrap=%h c=%h expected 1 0 0 00", sat_mode, ovf, wrap_cnt, c);
        end
        op(1'b1, MODE_LOAD, 8'h00, 8'h03);
        op(1'b1, MODE_SUB, 8'h05, 8'h00);
        checks++; if (c !== 8'h00 || cout !== 1'b1 || ovf !== 1'b1) begin
            failures++; $display("FAIL sat_sub1: got c=%h cout=%b ovf=%b expected 00 1 1", c, cout, ovf);
        end
        op(1'b1, MODE_SUB, 8'h05, 8'h00);
        checks++; if (c !== 8'h00 || cout !== 1'b1 || wrap_cnt !== 4'h2) begin
            failures++; $display("FAIL sat_sub2: got c=%h cout=%b wrap=%h expected 00 1 2", c, cout, wrap_cnt);
        end
        // Mode write on the same edge as an op: the op uses the old (saturate) mode.
        sat_wr = 1'b1; sat_in = 1'b0;
        op(1'b1, MODE_SUB, 8'h01, 8'h00);
        checks++; if (c !== 8'h00 || cout !== 1'b1 || sat_mode !== 1'b0) begin
            failures++; $display("FAIL sat_same_cycle: got c=%h cout=%b sat=%b expected 00 1 0", c, cout, sat_mode);
        end
        op(1'b1, MODE_SUB, 8'h01, 8'h00);
        checks++; if (c !== 8'hFF || cout !== 1'b1 || wrap_cnt !== 4'h4) begin
            failures++; $display("FAIL wrap_sub: got c=%h cout=%b wrap=%h expected ff 1 4", c, cout, wrap_cnt);
        end
        op(1'b1, MODE_SUB, 8'h00, 8'h00);
        checks++; if (c !== 8'hFF || cout !== 1'b0 || wrap_cnt !== 4'h4) begin
            failures++; $display("FAIL sub_step0: got c=%h cout=%b wrap=%h expected ff 0 4", c, cout, wrap_cnt);
        end
    endtask

    task automatic test_sat_add();
        sat_wr = 1'b1; sat_in = 1'b1;
        op(1'b1, MODE_LOAD, 8'h00, 8'hFF);
        op(1'b1, MODE_ADD, 8'h01, 8'h00);
        checks++; if (c !== 8'hFF || cout !== 1'b1 || wrap_cnt !== 4'h5) begin
            failures++; $display("FAIL sat_add: got c=%h cout=%b wrap=%h expected ff 1 5", c, cout, wrap_cnt);
        end
        op(1'b1, MODE_ADD, 8'h00, 8'h00);
        checks++; if (c !== 8'hFF || cout !== 1'b0) begin failures++; $display("FAIL add_step0: got c=%h cout=%b expected ff 0", c, cout); end
        sat_wr = 1'b1; sat_in = 1'b0;
        op(1'b0, MODE_HOLD, 8'h00, 8'h00);
    endtask

    task automatic test_priority();
        op(1'b1, MODE_LOAD, 8'h00, 8'hFF);
        clear = 1'b1;
        op(1'b1, MODE_ADD, 8'h01, 8'h00);
        checks++; if (c !== 8'h00 || cout !== 1'b0 || ovf !== 1'b0 || wrap_cnt !== 4'h0) begin
            failures++; $display("FAIL clear_priority: got c=%h cout=%b ovf=%b wrap=%h expected 00 0 0 0", c, cout, ovf, wrap_cnt);
        end
        op(1'b1, MODE_LOAD, 8'h00, 8'hFF);
        op(1'b0, MODE_ADD, 8'h01, 8'h00);
        checks++; if (c !== 8'hFF || cout !== 1'b0 || ovf !== 1'b0 || wrap_cnt !== 4'h0) begin
            failures++; $display("FAIL disabled_hold: got c=%h cout=%b ovf=%b wrap=%h expected ff 0 0 0", c, cout, ovf, wrap_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_c;
        logic [3:0] exp_w;
        exp_c = 8'hFF;
        exp_w = 4'h0;
        // c + 0xFF carries whenever c >= 1, so every add here carries and c drops by one.
        for (int i = 0; i < 20; i++) begin
            op(1'b1, MODE_ADD, 8'hFF, 8'h00);
            exp_c = exp_c - 8'h01;
            if (exp_w != 4'hF) exp_w = exp_w + 4'h1;
            checks++; if (cout !== 1'b1 || wrap_cnt !== exp_w || c !== exp_c) begin
                failures++; $display("FAIL b2b_%0d: got cout=%b wrap=%h c=%h expected 1 %h %h", i, cout, wrap_cnt, c, exp_c, exp_w);
            end
        end
        checks++; if (c !== 8'hEB || wrap_cnt !== 4'hF || ovf !== 1'b1) begin
            failures++; $display("FAIL b2b_final: got c=%h wrap=%h ovf=%b expected eb f 1", c, wrap_cnt, ovf);
        end
    endtask

    task automatic test_hold_load();
        op(1'b1, MODE_HOLD, 8'h33, 8'h00);
        checks++; if (c !== 8'hEB || cout !== 1'b0) begin failures++; $display("FAIL hold: got c=%h cout=%b expected eb 0", c, cout); end
        op(1'b1, MODE_LOAD, 8'h33, 8'hAB);
        checks++; if (c !== 8'hAB || cout !== 1'b0) begin failures++; $display("FAIL load: got c=%h cout=%b expected ab 0", c, cout); end
        checks++; if (ovf !== 1'b1 || wrap_cnt !== 4'hF) begin failures++; $display("FAIL load_flags: got ovf=%b wrap=%h expected 1 f", ovf, wrap_cnt); end
    endtask

    initial begin
        test_reset();
        test_wrap_add();
        test_sat_sub();
        test_sat_add();
        test_priority();
        test_back_to_back();
        test_hold_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sumador_acc_param.md
Name: sumador_acc_param

Overview:
Parametrised successor to the team's 8-bit counting adder. It is a registered accumulator with four selectable modes: hold, add step, subtract step, load. Features:
- configurable width;
- optional saturation instead of wrap-around;
- one-cycle carry/borrow pulse;
- sticky overflow flag;
- saturating wrap-event counter.

It sits behind the Tiny Tapeout top wrapper, which maps its result to uo_out and its carry to a uio output pin.

Parameters:
- WIDTH, 8, accumulator and operand width in bits (>= 2)
- WRAP_W, 4, width of wrap-event counter (>= 1)
- SAT_DEFAULT, 0, reset value of internal saturation-mode register (0 = wrap, 1 = saturate)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- enable  input  1  operation strobe; 0 = hold, cout forced 0
- mode  input  2  00 hold, 01 add, 10 subtract, 11 load
- step  input  WIDTH  operand for add/subtract
- load_val  input  WIDTH  value written in load mode
- sat_wr  input  1  write strobe for saturation-mode register
- sat_in  input  1  saturation-mode value written when sat_wr=1
- clear  input  1  synchronous clear of c, flags and wrap counter
- c  output  WIDTH  accumulator value (registered)
- cout  output  1  one-cycle pulse: carry (add) or borrow (subtract) on the previous op
- ovf  output  1  sticky: set by any carry/borrow, cleared by clear or rst
- wrap_cnt  output  WRAP_W  number of carry/borrow events, saturates at all-ones
- sat_mode  output  1  current saturation-mode register value

Behaviour:
- Reset (rst=1, async, takes effect immediately):
  - c=0, cout=0, ovf=0, wrap_cnt=0, sat_mode=SAT_DEFAULT.
  - Reset mid-operation discards the in-flight result; first valid op is on the first clk edge after rst deasserts.
- All outputs are registered. Latency from operands to c/cout is 1 cycle.
- sat_wr is independent of enable and clear. The new sat_mode applies from the next cycle's op; an op in the same cycle uses the old value.
- Priority per edge: clear > enable. On clear: c=0, cout=0, ovf=0, wrap_cnt=0, regardless of enable/mode.
- enable=0 (no clear): c holds, cout=0, ovf and wrap_cnt hold.
- enable=1, mode 00: c holds, cout=0.
- enable=1, mode 01 add: compute sum = {1'b0,c} + {1'b0,step} (WIDTH+1 bits).
  - carry = sum[WIDTH].
  - No carry: c=sum[WIDTH-1:0].
  - Carry, sat_mode=0: c=sum[WIDTH-1:0] (wrap).
  - Carry, sat_mode=1: c=all-ones.
- enable=1, mode 10 subtract: borrow = (step > c), unsigned.
  - No borrow: c=c-step.
  - Borrow, sat_mode=0: c=(c-step) mod 2^WIDTH.
  - Borrow, sat_mode=1: c=0.
- enable=1, mode 11 load: c=load_val, cout=0, flags unchanged.
- On add/subtract: cout=carry/borrow for that cycle only.
  - If carry/borrow: ovf=1; wrap_cnt increments unless already all-ones (then holds).
- Boundaries:
  - step=0 never produces carry/borrow.
  - c=all-ones plus step=1 gives carry; c becomes 0 (wrap) or stays all-ones (sat).
  - c=0 minus step=1 gives borrow; c becomes all-ones (wrap) or stays 0 (sat).
  - A saturated result still pulses cout and sets ovf.
  - Back-to-back carries pulse cout on consecutive cycles.

Decomposition:
- Package sumador_pkg:
  - mode localparams MODE_HOLD=2'b00, MODE_ADD=2'b01, MODE_SUB=2'b10, MODE_LOAD=2'b11;
  - helper constant for all-ones of WIDTH.
- Sub-module sumador_addsub_core (combinational):
  - inputs a, b, sub;
  - outputs result[WIDTH-1:0], cb (carry/borrow).
- Top holds registers, saturation mux, flags and wrap counter.

Test Plan (WIDTH=8, WRAP_W=4, SAT_DEFAULT=0):
1. Async reset: assert rst between clock edges with c=0x5A -> c=0, cout=0, ovf=0, wrap_cnt=0 immediately, before next edge.
2. Wrap add: load 0xF0, add step=0x20 -> c=0x10, cout=1 for one cycle, ovf=1, wrap_cnt=1. Next add of step=0x01 -> c=0x11, cout=0, ovf stays 1.
3. Saturating subtract: sat_wr=1, sat_in=1; load 0x03; subtract step=0x05 -> c=0x00, cout=1, ovf=1. Subtract again -> c=0x00, cout=1, wrap_cnt=2.
4. Priority: clear=1 with enable=1, mode=add, c=0xFF, step=0x01 -> c=0, cout=0, ovf=0, wrap_cnt=0. Repeat with clear=0 and enable=0 -> c holds, cout=0.
5. Counter saturation: 20 consecutive carrying adds (c=0xFF, step=0xFF, wrap) -> wrap_cnt stops at 0xF; cout pulses every cycle.
6. Hold/load: mode 00 with step=0x33 -> c unchanged. Load 0xAB with ovf=1 -> c=0xAB, cout=0, ovf remains 1.
